// File: rtl/mdu_ctrl_if.sv
// Command/result bundle between the EX stage and the multiply/divide controller.
// Signal names follow the pipeline's existing port names.
interface mdu_ctrl_if;
    logic        start;
    logic [3:0]  mdOp;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mdRes;

    modport master (
        output start, mdOp, srcA, srcB,
        input  busy, hi, lo, mdRes
    );

    modport slave (
        input  start, mdOp, srcA, srcB,
        output busy, hi, lo, mdRes
    );
endinterface

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide controller holding the architectural HI/LO registers.
// Results are computed at accept time and committed to HI/LO when the latency counter expires.
module mdu_ctrl #(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10
) (
    input logic      clk,
    input logic      rst_n,
    mdu_ctrl_if.slave md
);

    typedef enum logic [3:0] {
        OpNone  = 4'd0,
        OpMult  = 4'd1,
        OpMultu = 4'd2,
        OpDiv   = 4'd3,
        OpDivu  = 4'd4,
        OpMfhi  = 4'd5,
        OpMflo  = 4'd6,
        OpMthi  = 4'd7,
        OpMtlo  = 4'd8
    } md_op_e;

    localparam int unsigned MaxLat = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int unsigned CntW   = $clog2(MaxLat + 1);

    md_op_e op;
    assign op = md_op_e'(md.mdOp);

    logic [CntW-1:0] cnt_q;
    logic            busy_q;
    logic [31:0]     hi_q, lo_q, pend_hi_q, pend_lo_q;

    logic signed [63:0] sa_ext, sb_ext, prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        abs_a, abs_b, sdivisor, udivisor;
    logic [31:0]        q_mag, r_mag, q_s, r_s, q_u, r_u;

    always_comb begin
        sa_ext = {{32{md.srcA[31]}}, md.srcA};
        sb_ext = {{32{md.srcB[31]}}, md.srcB};
        prod_s = sa_ext * sb_ext;
        prod_u = {32'b0, md.srcA} * {32'b0, md.srcB};

        // Signed divide via magnitudes; 0x80000000 magnitude stays representable unsigned.
        abs_a    = md.srcA[31] ? (~md.srcA + 32'd1) : md.srcA;
        abs_b    = md.srcB[31] ? (~md.srcB + 32'd1) : md.srcB;
        sdivisor = (abs_b == 32'd0) ? 32'd1 : abs_b;
        udivisor = (md.srcB == 32'd0) ? 32'd1 : md.srcB;
        q_mag    = abs_a / sdivisor;
        r_mag    = abs_a % sdivisor;
        q_s      = (md.srcA[31] ^ md.srcB[31]) ? (~q_mag + 32'd1) : q_mag;
        r_s      = md.srcA[31] ? (~r_mag + 32'd1) : r_mag;
        q_u      = md.srcA / udivisor;
        r_u      = md.srcA % udivisor;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
        end else if (cnt_q != '0) begin
            cnt_q  <= cnt_q - CntW'(1);
            busy_q <= (cnt_q != CntW'(1));
            if (cnt_q == CntW'(1)) begin
                hi_q <= pend_hi_q;
                lo_q <= pend_lo_q;
            end
        end else if (md.start) begin
            unique case (op)
                OpMult, OpMultu: begin
                    pend_hi_q <= (op == OpMult) ? prod_s[63:32] : prod_u[63:32];
                    pend_lo_q <= (op == OpMult) ? prod_s[31:0] : prod_u[31:0];
                    cnt_q     <= CntW'(MULT_LAT);
                    busy_q    <= 1'b1;
                end
                OpDiv, OpDivu: begin
                    // Divide by zero commits the current HI/LO, i.e. leaves them untouched.
                    if (md.srcB == 32'd0) begin
                        pend_hi_q <= hi_q;
                        pend_lo_q <= lo_q;
                    end else begin
                        pend_hi_q <= (op == OpDiv) ? r_s : r_u;
                        pend_lo_q <= (op == OpDiv) ? q_s : q_u;
                    end
                    cnt_q  <= CntW'(DIV_LAT);
                    busy_q <= 1'b1;
                end
                OpMthi:  hi_q <= md.srcA;
                OpMtlo:  lo_q <= md.srcA;
                default: ;
            endcase
        end
    end

    always_comb begin
        md.mdRes = 32'd0;
        if (op == OpMfhi) begin
            md.mdRes = hi_q;
        end else if (op == OpMflo) begin
            md.mdRes = lo_q;
        end
    end

    assign md.busy = busy_q;
    assign md.hi   = hi_q;
    assign md.lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: latency, arithmetic corner cases, ignored starts and async reset.
module tb_mdu_ctrl;

    localparam logic [3:0] OpNone  = 4'd0;
    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpDivu  = 4'd4;
    localparam logic [3:0] OpMfhi  = 4'd5;
    localparam logic [3:0] OpMflo  = 4'd6;
    localparam logic [3:0] OpMthi  = 4'd7;
    localparam logic [3:0] OpMtlo  = 4'd8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    mdu_ctrl_if bus ();

    mdu_ctrl #(
        .MULT_LAT(5),
        .DIV_LAT (10)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .md   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; issues op on the next posedge, counts busy cycles, and
    // returns at the negedge of the first non-busy cycle. inject>0 raises a stray
    // MULT 2*3 start during that busy cycle.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int inject, output int cycles);
        bus.start = 1'b1;
        bus.mdOp  = op;
        bus.srcA  = a;
        bus.srcB  = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.mdOp  = OpNone;
        cycles    = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
            cycles++;
            if (cycles == inject) begin
                bus.start = 1'b1;
                bus.mdOp  = OpMult;
                bus.srcA  = 32'd2;
                bus.srcB  = 32'd3;
            end else begin
                bus.start = 1'b0;
                bus.mdOp  = OpNone;
            end
        end
        bus.start = 1'b0;
        bus.mdOp  = OpNone;
    endtask

    task automatic move_to(input logic [3:0] op, input logic [31:0] a);
        bus.start = 1'b1;
        bus.mdOp  = op;
        bus.srcA  = a;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.mdOp  = OpNone;
        @(negedge clk);
    endtask

    int cyc;
    int busy_seen;

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.mdOp  = OpNone;
        bus.srcA  = '0;
        bus.srcB  = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check_eq("reset_busy", {31'b0, bus.busy}, 32'd0);
        check_eq("reset_hi", bus.hi, 32'd0);
        check_eq("reset_lo", bus.lo, 32'd0);
        bus.mdOp = OpMfhi;
        #1 check_eq("reset_mfhi", bus.mdRes, 32'd0);
        bus.mdOp = OpMflo;
        #1 check_eq("reset_mflo", bus.mdRes, 32'd0);
        bus.mdOp = OpNone;
        @(negedge clk);

        run_op(OpMult, 32'hFFFF_FFFE, 32'd3, 0, cyc);
        check_eq("mult_lat", cyc, 32'd5);
        check_eq("mult_hi", bus.hi, 32'hFFFF_FFFF);
        check_eq("mult_lo", bus.lo, 32'hFFFF_FFFA);
        bus.mdOp = OpMfhi;
        #1 check_eq("mfhi_read", bus.mdRes, 32'hFFFF_FFFF);
        bus.mdOp = OpMflo;
        #1 check_eq("mflo_read", bus.mdRes, 32'hFFFF_FFFA);
        bus.mdOp = 4'd9;
        #1 check_eq("op9_read", bus.mdRes, 32'd0);
        bus.mdOp = OpNone;
        @(negedge clk);

        run_op(OpMultu, 32'hFFFF_FFFE, 32'd3, 0, cyc);
        check_eq("multu_lat", cyc, 32'd5);
        check_eq("multu_hi", bus.hi, 32'h0000_0002);
        check_eq("multu_lo", bus.lo, 32'hFFFF_FFFA);

        run_op(OpDiv, 32'hFFFF_FFF9, 32'd2, 0, cyc);
        check_eq("div_lat", cyc, 32'd10);
        check_eq("div_lo", bus.lo, 32'hFFFF_FFFD);
        check_eq("div_hi", bus.hi, 32'hFFFF_FFFF);

        run_op(OpDivu, 32'd7, 32'd2, 0, cyc);
        check_eq("divu_lat", cyc, 32'd10);
        check_eq("divu_lo", bus.lo, 32'd3);
        check_eq("divu_hi", bus.hi, 32'd1);

        // Opcode 15 with start must not disturb anything.
        bus.start = 1'b1;
        bus.mdOp  = 4'd15;
        bus.srcA  = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.mdOp  = OpNone;
        @(negedge clk);
        check_eq("op15_busy", {31'b0, bus.busy}, 32'd0);
        check_eq("op15_hi", bus.hi, 32'd1);
        check_eq("op15_lo", bus.lo, 32'd3);

        move_to(OpMthi, 32'h0000_1234);
        check_eq("mthi_busy", {31'b0, bus.busy}, 32'd0);
        check_eq("mthi_hi", bus.hi, 32'h0000_1234);
        move_to(OpMtlo, 32'h0000_5678);
        check_eq("mtlo_lo", bus.lo, 32'h0000_5678);
        check_eq("mtlo_hi_kept", bus.hi, 32'h0000_1234);

        run_op(OpDiv, 32'd5, 32'd0, 0, cyc);
        check_eq("div0_lat", cyc, 32'd10);
        check_eq("div0_hi", bus.hi, 32'h0000_1234);
        check_eq("div0_lo", bus.lo, 32'h0000_5678);

        run_op(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 0, cyc);
        check_eq("divovf_lo", bus.lo, 32'h8000_0000);
        check_eq("divovf_hi", bus.hi, 32'd0);

        // Stray MULT during a DIVU is ignored; result and timing unaffected.
        run_op(OpDivu, 32'd100, 32'd7, 3, cyc);
        check_eq("ignore_lat", cyc, 32'd10);
        check_eq("ignore_lo", bus.lo, 32'd14);
        check_eq("ignore_hi", bus.hi, 32'd2);

        // Back-to-back MULT in the first idle cycle.
        run_op(OpMult, 32'd2, 32'd3, 0, cyc);
        check_eq("b2b_lat", cyc, 32'd5);
        check_eq("b2b_lo", bus.lo, 32'd6);
        check_eq("b2b_hi", bus.hi, 32'd0);

        // Async reset mid-MULT aborts with no later commit.
        move_to(OpMthi, 32'h0000_ABCD);
        bus.start = 1'b1;
        bus.mdOp  = OpMult;
        bus.srcA  = 32'hFFFF_FFFE;
        bus.srcB  = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.mdOp  = OpNone;
        repeat (3) @(negedge clk);
        check_eq("pre_rst_busy", {31'b0, bus.busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_busy", {31'b0, bus.busy}, 32'd0);
        check_eq("rst_hi", bus.hi, 32'd0);
        check_eq("rst_lo", bus.lo, 32'd0);
        rst_n = 1'b1;
        busy_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.busy || bus.hi != 32'd0 || bus.lo != 32'd0) busy_seen++;
        end
        check_eq("post_rst_idle", busy_seen, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
